alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Sequencer and arbiter that shares one 8-bit ALU between two command requesters, such as the keypad calculator front-end and an accumulator/macro unit. It accepts one operation at a time from either requester, drives the ALU operand and opcode inputs from registered copies, waits a fixed settle time, captures result and flags, and signals completion to the owning requester. It sits between the requesters and the ALU; the BCD conversion and display path consume its registered result.

## Interface
Parameters:
- WIDTH, 8, operand/result width
- OPW, 4, opcode width
- ALU_LAT, 1, ALU settle cycles between operand issue and capture (legal 1..7)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  command request, held until granted
- a0, b0 / a1, b1  in  WIDTH  operands, valid while reqN high
- op0 / op1  in  OPW  ALU opcode, valid while reqN high
- gnt0 / gnt1  out  1  one-cycle pulse: command accepted, operands latched
- done0 / done1  out  1  one-cycle pulse: result/flags valid for that requester
- busy  out  1  high from accept edge until capture edge
- result  out  WIDTH  registered ALU result of last completed op
- zero, carry, overflow  out  1  registered ALU flags of last completed op
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_op  out  OPW  registered opcode to ALU
- alu_result  in  WIDTH  ALU result
- alu_zero, alu_carry, alu_overflow  in  1  ALU flags

## Operation
- States: IDLE, ISSUE. Reset → IDLE.
- IDLE, no req: hold all outputs, gnt/done low.
- IDLE, one req: accept it. Latch aN/bN/opN into alu_a/alu_b/alu_op, pulse gntN, set busy, load settle counter with ALU_LAT, go ISSUE.
- IDLE, both req: accept the requester selected by the priority pointer `prio` (reset 0).
- After any accept, prio ← index of the requester not served.
- ISSUE: decrement counter each cycle. On the edge where the counter reaches zero: result/flags ← alu_* inputs, pulse doneN for the owner, clear busy, go IDLE.
- alu_a/alu_b/alu_op hold their last values until the next accept. They are never changed during ISSUE.
- Requests arriving during ISSUE are not sampled. The requester keeps req high and is considered in the next IDLE cycle.
- A requester drops req in the cycle it sees gnt. A req still high after gnt is treated as a new command.
- A req dropped before grant withdraws the command. No gnt or done is issued for it.
- Opcodes pass through unchecked. Flag meaning is defined by the ALU.
- Reset: all outputs 0 (result, flags, alu_*, gnt*, done*, busy), state IDLE, prio 0, counter 0.

## Timing
- Accept at edge k: gntN, busy, alu_a/alu_b/alu_op valid in cycle k+1.
- Capture at edge k+ALU_LAT: doneN, result, flags valid in cycle k+ALU_LAT+1.
- busy low in cycle k+ALU_LAT+1.
- gnt and done are single-cycle; they never coincide for the same command.
- Next accept is at the earliest at edge k+ALU_LAT+1, when done of the previous op is visible. Throughput is one op per ALU_LAT+1 cycles.
- Reset sampled high mid-ISSUE: the op aborts and no done is issued. The next cycle shows reset values.
- Reset and req high on the same edge: reset wins, no accept.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority. Requester 0 wins every simultaneous request, the prio pointer is not implemented, and requester 1 may starve.
- Not defined (default): round-robin as described in Operation.

## Test plan
- Reset, then req0 with a0=8'd100, b0=8'd55, op0=ADD (ALU_LAT=1) → gnt0 in cycle after accept; done0 two cycles after accept; result=8'd155, carry=0, zero=0.
- req0 and req1 high on the same edge after reset (a0=5,b0=3 SUB; a1=200,b1=100 ADD) → requester 0 served first (result 2); requester 1 accepted at the next IDLE edge (result 44, carry=1). Both requests kept high → grants alternate 0,1,0,1.
- Same stimulus with `ALU_ARB_FIXED_PRIO_EN` and both reqs held continuously → only gnt0/done0 pulse; gnt1 never asserts.
- ALU_LAT=3, req1 a1=8'd255, b1=8'd1, ADD → alu_* stable 3 cycles; done1 at accept+4; result=0, zero=1, carry=1.
- reset asserted in the first ISSUE cycle → no done0/done1; all outputs 0 next cycle. A new req is accepted normally afterwards.
- req1 raised then dropped while ISSUE serves requester 0 → no gnt1/done1 ever issued.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two requesters. Each accepted command
// drives registered operands to the ALU, waits ALU_LAT cycles, then captures the
// result and flags and pulses done to the requester that owns the command.
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority (no
// round-robin pointer; requester 1 may starve).
module alu_share_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned OPW     = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [OPW-1:0]   op0,
    input  logic [OPW-1:0]   op1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow
);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    localparam logic [2:0] LatInit = 3'(ALU_LAT);

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             sel;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             prio_q, prio_d;
`endif

    // Next-state logic: arbitration and operand latch in idle, settle countdown and capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        busy_d   = busy_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        sel      = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
        prio_d   = prio_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    sel = ~req0;
`else
                    // Pointer only matters on a tie; it then favours the one not served last
                    sel    = (req0 && req1) ? prio_q : req1;
                    prio_d = ~sel;
`endif
                    owner_d  = sel;
                    alu_a_d  = sel ? a1 : a0;
                    alu_b_d  = sel ? b1 : b0;
                    alu_op_d = sel ? op1 : op0;
                    gnt0_d   = ~sel;
                    gnt1_d   = sel;
                    busy_d   = 1'b1;
                    cnt_d    = LatInit;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    cnt_d    = '0;
                    result_d = alu_result;
                    zero_d   = alu_zero;
                    carry_d  = alu_carry;
                    ovf_d    = alu_overflow;
                    done0_d  = ~owner_q;
                    done1_d  = owner_q;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset aborts any op in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            prio_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            prio_q   <= prio_d;
`endif
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign busy     = busy_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: one instance at ALU_LAT=1 and one at ALU_LAT=3,
// each driven by a small behavioural ALU (op 0 = ADD, 1 = SUB, others = AND).
module tb_alu_share_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    // ALU_LAT = 1 instance
    logic       req0 = 0, req1 = 0;
    logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic [3:0] op0 = 0, op1 = 0;
    logic       gnt0, gnt1, done0, done1, busy, zero, carry, overflow;
    logic [7:0] result, alu_a, alu_b, alu_result;
    logic [3:0] alu_op;
    logic       alu_zero, alu_carry, alu_overflow;

    // ALU_LAT = 3 instance
    logic       q0 = 0, q1 = 0;
    logic [7:0] c0 = 0, d0 = 0, c1 = 0, d1 = 0;
    logic [3:0] p0 = 0, p1 = 0;
    logic       g0_3, g1_3, dn0_3, dn1_3, busy_3, zero_3, carry_3, ovf_3;
    logic [7:0] result_3, alu_a_3, alu_b_3, alu_res_3;
    logic [3:0] alu_op_3;
    logic       alu_z_3, alu_c_3, alu_v_3;

    function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd1: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[7:0]; c = s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            default: begin
                r = a & b; c = 1'b0; v = 1'b0;
            end
        endcase
        return {v, c, (r == 8'd0), r};
    endfunction

    assign {alu_overflow, alu_carry, alu_zero, alu_result} = alu_f(alu_a, alu_b, alu_op);
    assign {alu_v_3, alu_c_3, alu_z_3, alu_res_3} = alu_f(alu_a_3, alu_b_3, alu_op_3);

    alu_share_arbiter #(.WIDTH(8), .OPW(4), .ALU_LAT(1)) u_dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy),
        .result(result), .zero(zero), .carry(carry), .overflow(overflow),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow)
    );

    alu_share_arbiter #(.WIDTH(8), .OPW(4), .ALU_LAT(3)) u_dut3 (
        .clock(clock), .reset(reset),
        .req0(q0), .req1(q1), .a0(c0), .b0(d0), .a1(c1), .b1(d1), .op0(p0), .op1(p1),
        .gnt0(g0_3), .gnt1(g1_3), .done0(dn0_3), .done1(dn1_3), .busy(busy_3),
        .result(result_3), .zero(zero_3), .carry(carry_3), .overflow(ovf_3),
        .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_op(alu_op_3),
        .alu_result(alu_res_3), .alu_zero(alu_z_3), .alu_carry(alu_c_3),
        .alu_overflow(alu_v_3)
    );

    // Advance one edge; sample and drive 1 time unit after it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {gnt0, gnt1, done0, done1, busy});
        end
        total++;
        if ({result, zero, carry, overflow, alu_a, alu_b, alu_op} !== 31'b0) begin
            bad++; $display("FAIL reset_data got=%h want=0",
                            {result, zero, carry, overflow, alu_a, alu_b, alu_op});
        end
    endtask

    task automatic test_single();
        req0 = 1; a0 = 8'd100; b0 = 8'd55; op0 = 4'd0;
        step();
        total++;
        if ({gnt0, gnt1, busy, done0} !== 4'b1010) begin
            bad++; $display("FAIL single_gnt got=%b want=1010", {gnt0, gnt1, busy, done0});
        end
        total++;
        if ({alu_a, alu_b, alu_op} !== {8'd100, 8'd55, 4'd0}) begin
            bad++; $display("FAIL single_alu_in got=%h want=%h", {alu_a, alu_b, alu_op},
                            {8'd100, 8'd55, 4'd0});
        end
        req0 = 0;
        step();
        total++;
        if ({done0, done1, gnt0, busy} !== 4'b1000) begin
            bad++; $display("FAIL single_done got=%b want=1000", {done0, done1, gnt0, busy});
        end
        total++;
        if ({result, zero, carry, overflow} !== {8'd155, 3'b001}) begin
            bad++; $display("FAIL single_result got=%0d z%b c%b v%b want=155 z0 c0 v1",
                            result, zero, carry, overflow);
        end
        step();
        total++;
        if ({done0, gnt0, busy} !== 3'b000) begin
            bad++; $display("FAIL single_idle got=%b want=000", {done0, gnt0, busy});
        end
    endtask

    task automatic test_both();
        apply_reset();
        req0 = 1; a0 = 8'd5; b0 = 8'd3; op0 = 4'd1;
        req1 = 1; a1 = 8'd200; b1 = 8'd100; op1 = 4'd0;
        step();
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++; $display("FAIL both_first_gnt got=%b want=10", {gnt0, gnt1});
        end
        req0 = 0;
        step();
        total++;
        if ({done0, gnt1, result} !== {2'b10, 8'd2}) begin
            bad++; $display("FAIL both_first_done got=%b/%b/%0d want=1/0/2", done0, gnt1, result);
        end
        step();
        total++;
        if ({gnt1, gnt0, alu_a, alu_b} !== {2'b10, 8'd200, 8'd100}) begin
            bad++; $display("FAIL both_second_gnt got=%b%b a=%0d b=%0d want=10 a=200 b=100",
                            gnt1, gnt0, alu_a, alu_b);
        end
        req1 = 0;
        step();
        total++;
        if ({done1, result, carry, zero} !== {1'b1, 8'd44, 2'b10}) begin
            bad++; $display("FAIL both_second_done got=%b %0d c%b z%b want=1 44 c1 z0",
                            done1, result, carry, zero);
        end
    endtask

    task automatic test_alternate();
        int seen[$];
        int when[$];
        int exp;
        apply_reset();
        req0 = 1; a0 = 8'd5; b0 = 8'd3; op0 = 4'd1;
        req1 = 1; a1 = 8'd200; b1 = 8'd100; op1 = 4'd0;
        for (int c = 0; c < 40 && seen.size() < 4; c++) begin
            step();
            if (gnt0 && gnt1) begin
                total++; bad++;
                $display("FAIL alt_both_gnt got=11 want=one-hot");
            end
            if (gnt0) begin seen.push_back(0); when.push_back(c); end
            if (gnt1) begin seen.push_back(1); when.push_back(c); end
        end
        req0 = 0; req1 = 0;
        total++;
        if (seen.size() != 4) begin
            bad++; $display("FAIL alt_count got=%0d want=4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                exp = 0;
`else
                exp = i % 2;
`endif
                total++;
                if (seen[i] != exp) begin
                    bad++; $display("FAIL alt_order[%0d] got=%0d want=%0d", i, seen[i], exp);
                end
                if (i > 0) begin
                    total++;
                    if (when[i] - when[i-1] != 2) begin
                        bad++; $display("FAIL alt_spacing[%0d] got=%0d want=2", i,
                                        when[i] - when[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_withdraw();
        apply_reset();
        req0 = 1; a0 = 8'd1; b0 = 8'd2; op0 = 4'd0;
        step();
        total++;
        if (gnt0 !== 1'b1) begin
            bad++; $display("FAIL wd_gnt0 got=%b want=1", gnt0);
        end
        req0 = 0;
        req1 = 1; a1 = 8'd9; b1 = 8'd9; op1 = 4'd0;
        step();
        total++;
        if ({done0, gnt1, result} !== {2'b10, 8'd3}) begin
            bad++; $display("FAIL wd_done0 got=%b/%b/%0d want=1/0/3", done0, gnt1, result);
        end
        req1 = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({gnt1, done1, busy} !== 3'b000) begin
                bad++; $display("FAIL wd_quiet[%0d] got=%b want=000", i, {gnt1, done1, busy});
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req0 = 1; a0 = 8'd20; b0 = 8'd30; op0 = 4'd0;
        step();
        total++;
        if (gnt0 !== 1'b1) begin
            bad++; $display("FAIL rm_gnt0 got=%b want=1", gnt0);
        end
        // Keep req0 high so reset must also beat a pending accept
        reset = 1;
        step();
        total++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b0) begin
            bad++; $display("FAIL rm_ctrl got=%b want=00000", {gnt0, gnt1, done0, done1, busy});
        end
        total++;
        if ({result, alu_a, alu_b, alu_op, zero, carry, overflow} !== 31'b0) begin
            bad++; $display("FAIL rm_data got=%h want=0",
                            {result, alu_a, alu_b, alu_op, zero, carry, overflow});
        end
        reset = 0; req0 = 0;
        step();
        total++;
        if ({done0, done1} !== 2'b00) begin
            bad++; $display("FAIL rm_no_done got=%b want=00", {done0, done1});
        end
        req1 = 1; a1 = 8'd7; b1 = 8'd9; op1 = 4'd0;
        step();
        total++;
        if ({gnt1, gnt0} !== 2'b10) begin
            bad++; $display("FAIL rm_regnt got=%b want=10", {gnt1, gnt0});
        end
        req1 = 0;
        step();
        total++;
        if ({done1, result} !== {1'b1, 8'd16}) begin
            bad++; $display("FAIL rm_redone got=%b/%0d want=1/16", done1, result);
        end
    endtask

    task automatic test_lat3();
        apply_reset();
        q1 = 1; c1 = 8'd255; d1 = 8'd1; p1 = 4'd0;
        step();
        total++;
        if ({g1_3, busy_3, alu_a_3, alu_b_3} !== {2'b11, 8'd255, 8'd1}) begin
            bad++; $display("FAIL l3_gnt got=%b%b a=%0d b=%0d want=11 a=255 b=1",
                            g1_3, busy_3, alu_a_3, alu_b_3);
        end
        q1 = 0;
        q0 = 1; c0 = 8'h11; d0 = 8'h22; p0 = 4'd1;
        step();
        total++;
        if ({alu_a_3, g0_3, dn1_3, busy_3} !== {8'd255, 3'b001}) begin
            bad++; $display("FAIL l3_c2 got=a%0d g0%b d1%b busy%b want=a255 g0 0 d1 0 busy1",
                            alu_a_3, g0_3, dn1_3, busy_3);
        end
        q0 = 0;
        step();
        total++;
        if ({alu_a_3, alu_b_3, dn1_3, busy_3} !== {8'd255, 8'd1, 2'b01}) begin
            bad++; $display("FAIL l3_c3 got=a%0d b%0d d1%b busy%b want=a255 b1 d1 0 busy1",
                            alu_a_3, alu_b_3, dn1_3, busy_3);
        end
        step();
        total++;
        if ({dn1_3, dn0_3, busy_3, alu_a_3} !== {3'b100, 8'd255}) begin
            bad++; $display("FAIL l3_done got=%b%b%b a%0d want=100 a255",
                            dn1_3, dn0_3, busy_3, alu_a_3);
        end
        total++;
        if ({result_3, zero_3, carry_3, ovf_3} !== {8'd0, 3'b110}) begin
            bad++; $display("FAIL l3_result got=%0d z%b c%b v%b want=0 z1 c1 v0",
                            result_3, zero_3, carry_3, ovf_3);
        end
        step();
        total++;
        if ({g0_3, g1_3, dn1_3, busy_3} !== 4'b0000) begin
            bad++; $display("FAIL l3_after got=%b want=0000", {g0_3, g1_3, dn1_3, busy_3});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_alternate();
        test_withdraw();
        test_reset_mid();
        test_lat3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
